// File: rtl/pc_gen.sv
// Fetch-stage program counter: priority select of reset / exception / eret / redirect / stall / increment.
// One-cycle latency from deciding edge to pc; redirects arriving under stall are parked and replayed on release.
module pc_gen #(
    parameter int          WIDTH      = 32,
    parameter logic [31:0] RESET_PC   = 32'h0000_3000,
    parameter logic [31:0] EXC_VECTOR = 32'h0000_4180,
    parameter int          INC        = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             stall,
    input  logic             redir_valid,
    input  logic [WIDTH-1:0] redir_target,
    input  logic             exc_req,
    input  logic             eret,
    input  logic [WIDTH-1:0] epc,
    output logic [WIDTH-1:0] pc,
    output logic [WIDTH-1:0] pc_plus_inc,
    output logic             pend_valid,
    output logic             adel
);

    localparam logic [WIDTH-1:0] L_RESET_PC = WIDTH'(RESET_PC);
    localparam logic [WIDTH-1:0] L_EXC_VEC  = WIDTH'(EXC_VECTOR);
    localparam logic [WIDTH-1:0] L_INC      = WIDTH'(INC);

    logic [WIDTH-1:0] r_pc;
    logic [WIDTH-1:0] r_pend_target;
    logic             r_pend_valid;
    logic [WIDTH-1:0] w_pc_plus_inc;

    assign w_pc_plus_inc = r_pc + L_INC;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_pc          <= L_RESET_PC;
            r_pend_valid  <= 1'b0;
            r_pend_target <= '0;
        end else if (exc_req) begin
            r_pc         <= L_EXC_VEC;
            r_pend_valid <= 1'b0;
        end else if (eret) begin
            r_pc         <= epc;
            r_pend_valid <= 1'b0;
        end else if (stall) begin
            // Newest redirect wins; pc is frozen until the stall releases.
            if (redir_valid) begin
                r_pend_target <= redir_target;
                r_pend_valid  <= 1'b1;
            end
        end else if (redir_valid) begin
            r_pc         <= redir_target;
            r_pend_valid <= 1'b0;
        end else if (r_pend_valid) begin
            r_pc         <= r_pend_target;
            r_pend_valid <= 1'b0;
        end else begin
            r_pc <= w_pc_plus_inc;
        end
    end

    assign pc          = r_pc;
    assign pc_plus_inc = w_pc_plus_inc;
    assign pend_valid  = r_pend_valid;
    assign adel        = |r_pc[1:0];

endmodule

// File: tb/tb_pc_gen.sv
// Directed checks of pc_gen: 32-bit default instance plus a 16-bit wrap instance.
module tb_pc_gen;

    logic        clk;
    logic        reset;
    logic        stall;
    logic        redir_valid;
    logic [31:0] redir_target;
    logic        exc_req;
    logic        eret;
    logic [31:0] epc;
    logic [31:0] pc;
    logic [31:0] pc_plus_inc;
    logic        pend_valid;
    logic        adel;

    logic [15:0] pc_b;
    logic [15:0] pc_plus_inc_b;
    logic        pend_valid_b;
    logic        adel_b;

    int n_checks = 0;
    int n_errors = 0;

    pc_gen u_dut (
        .clk          (clk),
        .reset        (reset),
        .stall        (stall),
        .redir_valid  (redir_valid),
        .redir_target (redir_target),
        .exc_req      (exc_req),
        .eret         (eret),
        .epc          (epc),
        .pc           (pc),
        .pc_plus_inc  (pc_plus_inc),
        .pend_valid   (pend_valid),
        .adel         (adel)
    );

    pc_gen #(
        .WIDTH    (16),
        .RESET_PC (32'h0000_FFF8)
    ) u_dut16 (
        .clk          (clk),
        .reset        (reset),
        .stall        (1'b0),
        .redir_valid  (1'b0),
        .redir_target (16'h0000),
        .exc_req      (1'b0),
        .eret         (1'b0),
        .epc          (16'h0000),
        .pc           (pc_b),
        .pc_plus_inc  (pc_plus_inc_b),
        .pend_valid   (pend_valid_b),
        .adel         (adel_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        stall        = 1'b0;
        redir_valid  = 1'b0;
        redir_target = 32'h0;
        exc_req      = 1'b0;
        eret         = 1'b0;
        epc          = 32'h0;
    endtask

    initial begin
        idle();
        reset = 1'b1;
        #2;
        step();
        reset = 1'b0;
        check("rst_pc",       pc,                  32'h3000);
        check("rst_ppi",      pc_plus_inc,         32'h3004);
        check("rst_pend",     32'(pend_valid),     32'h0);
        check("rst_adel",     32'(adel),           32'h0);
        check("w16_rst",      32'(pc_b),           32'hFFF8);
        step();
        check("run1_pc",      pc,                  32'h3004);
        check("w16_pc1",      32'(pc_b),           32'hFFFC);
        check("w16_ppi1",     32'(pc_plus_inc_b),  32'h0000);
        step();
        check("run2_pc",      pc,                  32'h3008);
        check("run2_ppi",     pc_plus_inc,         32'h300C);
        check("w16_wrap",     32'(pc_b),           32'h0000);
        check("w16_pend",     32'(pend_valid_b),   32'h0);
        // Redirect taken at pc=0x3008.
        redir_valid = 1'b1; redir_target = 32'h3100;
        step();
        idle();
        check("w16_pc3",      32'(pc_b),           32'h0004);
        check("redir_pc",     pc,                  32'h3100);
        check("redir_pend",   32'(pend_valid),     32'h0);
        step();
        check("redir_seq",    pc,                  32'h3104);
        redir_valid = 1'b1; redir_target = 32'h3010;
        step();
        check("to3010",       pc,                  32'h3010);
        // Three stall cycles; second redirect overwrites first.
        stall = 1'b1; redir_valid = 1'b1; redir_target = 32'h3200;
        step();
        check("st1_pc",       pc,                  32'h3010);
        check("st1_pend",     32'(pend_valid),     32'h1);
        redir_target = 32'h3300;
        step();
        check("st2_pc",       pc,                  32'h3010);
        redir_valid = 1'b0;
        step();
        check("st3_pc",       pc,                  32'h3010);
        check("st3_pend",     32'(pend_valid),     32'h1);
        stall = 1'b0;
        step();
        check("replay_pc",    pc,                  32'h3300);
        check("replay_pend",  32'(pend_valid),     32'h0);
        step();
        check("replay_seq",   pc,                  32'h3304);
        // Exception under stall with a pending redirect.
        stall = 1'b1; redir_valid = 1'b1; redir_target = 32'h3300;
        step();
        check("pend_again",   32'(pend_valid),     32'h1);
        check("pend_hold",    pc,                  32'h3304);
        redir_valid = 1'b0; exc_req = 1'b1;
        step();
        check("exc_pc",       pc,                  32'h4180);
        check("exc_pend",     32'(pend_valid),     32'h0);
        idle();
        step();
        check("exc_seq",      pc,                  32'h4184);
        eret = 1'b1; epc = 32'h3010;
        step();
        check("eret_pc",      pc,                  32'h3010);
        exc_req = 1'b1;
        step();
        check("exc_eret_pc",  pc,                  32'h4180);
        idle();
        // Misaligned target loads as given and flags adel.
        redir_valid = 1'b1; redir_target = 32'h3102;
        step();
        idle();
        check("mis_pc",       pc,                  32'h3102);
        check("mis_adel",     32'(adel),           32'h1);
        check("mis_ppi",      pc_plus_inc,         32'h3106);
        step();
        check("mis_seq",      pc,                  32'h3106);
        // Live redirect on release beats the parked one.
        stall = 1'b1; redir_valid = 1'b1; redir_target = 32'h3500;
        step();
        stall = 1'b0; redir_target = 32'h3600;
        step();
        idle();
        check("live_pc",      pc,                  32'h3600);
        check("live_pend",    32'(pend_valid),     32'h0);
        check("live_adel",    32'(adel),           32'h0);
        step();
        check("live_seq",     pc,                  32'h3604);
        // Reset during stall discards the pending redirect.
        stall = 1'b1; redir_valid = 1'b1; redir_target = 32'h3700;
        step();
        redir_valid = 1'b0; reset = 1'b1;
        step();
        check("rst2_pc",      pc,                  32'h3000);
        check("rst2_pend",    32'(pend_valid),     32'h0);
        reset = 1'b0; stall = 1'b0;
        step();
        check("rst2_seq",     pc,                  32'h3004);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/pc_gen.md
Name: pc_gen

Overview:
Parametrised program-counter generator for the fetch stage of the pipelined MIPS core. It holds the fetch PC and selects the next PC by priority: reset, exception vector, exception return, branch/jump redirect, stall hold, or sequential increment. A redirect that arrives while fetch is stalled is buffered and applied when the stall releases. It also flags misaligned fetch addresses for the exception unit.

Parameters:
WIDTH, 32, address width in bits (>= 8).
RESET_PC, 32'h0000_3000, PC value loaded on reset; truncated to WIDTH.
EXC_VECTOR, 32'h0000_4180, PC loaded on exception entry; truncated to WIDTH.
INC, 4, sequential increment in bytes.

Ports:
clk  input  1  clock, all state updates on rising edge
reset  input  1  synchronous, active-high; clock clk
stall  input  1  hold PC (hazard/multicycle stall)
redir_valid  input  1  branch/jump taken this cycle
redir_target  input  WIDTH  branch/jump destination
exc_req  input  1  exception taken; go to EXC_VECTOR
eret  input  1  return from exception
epc  input  WIDTH  return address for eret
pc  output  WIDTH  current fetch PC (registered)
pc_plus_inc  output  WIDTH  pc + INC (combinational, wraps modulo 2^WIDTH)
pend_valid  output  1  a buffered redirect is waiting (registered)
adel  output  1  pc[1:0] != 0 (combinational from pc)

Behaviour:
- Reset (sync): pc <= RESET_PC; pend_valid <= 0; pend_target <= 0. Overrides all other inputs. No initial block; the value is defined only after the first reset edge.
- Next-state priority per rising edge, with reset deasserted:
  1. exc_req: pc <= EXC_VECTOR; pend_valid <= 0. Applies even if stall=1.
  2. eret (exc_req=0): pc <= epc; pend_valid <= 0. Applies even if stall=1.
  3. stall=1: pc holds. If redir_valid=1, then pend_target <= redir_target and pend_valid <= 1. A newer redirect overwrites an older pending one. Otherwise pending state holds.
  4. stall=0 and redir_valid=1: pc <= redir_target; pend_valid <= 0. A live redirect beats a pending one.
  5. stall=0 and pend_valid=1: pc <= pend_target; pend_valid <= 0.
  6. Otherwise: pc <= pc + INC, truncated to WIDTH. At all-ones minus INC+1 it wraps to low addresses; no flag is raised.
- Latency: every selection above is visible on pc exactly one cycle after the deciding edge. pc_plus_inc and adel have zero latency from pc.
- exc_req and eret asserted together: exc_req wins.
- adel has no side effects. Misaligned targets are loaded as given; the consumer raises AdEL.
- Reset mid-stall with a pending redirect: the pending redirect is discarded.
- All arithmetic is unsigned and WIDTH bits; INC is zero-extended.

Test Plan:
- Reset then 3 free-run cycles -> pc = 0x3000, 0x3004, 0x3008, 0x300C; pc_plus_inc = pc+4; pend_valid = 0.
- At pc=0x3008, redir_valid=1 with target 0x3100, no stall -> next pc = 0x3100, then 0x3104.
- stall=1 for 3 cycles at pc=0x3010. Redirect 0x3200 in stall cycle 1, then 0x3300 in stall cycle 2 -> pc holds 0x3010 and pend_valid=1. After stall drops, pc = 0x3300, pend_valid=0, then 0x3304.
- stall=1 with pending 0x3300; exc_req=1 -> pc = 0x4180 next cycle and pend_valid=0. Later eret=1 with epc=0x3010 -> pc = 0x3010. exc_req and eret together -> 0x4180.
- Redirect to 0x3102 -> adel=1 while pc=0x3102, and the next sequential pc = 0x3106. Reset asserted during a stall with a pending redirect -> pc = 0x3000 and pend_valid=0.
- WIDTH=16, RESET_PC=16'hFFF8 -> pc sequence FFF8, FFFC, 0000 (wrap), 0004.
